// File: rtl/mc_controller_pkg.sv
// Shared encodings for the multicycle RISC-V control unit: FSM states, opcodes,
// datapath mux selects and the ALU operation codes.
package mc_controller_pkg;

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECR    = 4'd6;
  localparam logic [3:0] S_EXECI    = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BEQ      = 4'd9;
  localparam logic [3:0] S_JAL      = 4'd10;
  localparam logic [3:0] S_HALT     = 4'd11;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b1000;
  localparam logic [3:0] ALU_SRL = 4'b0101;
  localparam logic [3:0] ALU_SRA = 4'b1101;

  typedef struct packed {
    logic       pc_update;
    logic       branch;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       illegal;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } ctrl_t;

  function automatic logic [1:0] imm_src(input logic [6:0] opcode);
    case (opcode)
      OP_SW:   return IMM_S;
      OP_BEQ:  return IMM_B;
      OP_JAL:  return IMM_J;
      default: return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/mc_controller_aludec.sv
// ALU decoder: maps ALUOp plus the instruction function fields to ALUControl.
module mc_controller_aludec
  import mc_controller_pkg::*;
(
  input  logic       opb5,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic [1:0] alu_op,
  output logic [3:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // bit 30 only means subtract for register-register ops; in I-type it is immediate data
          3'b000:  alu_control = (opb5 & funct7b5) ? ALU_SUB : ALU_ADD;
          3'b101:  alu_control = funct7b5 ? ALU_SRA : ALU_SRL;
          default: alu_control = {1'b0, funct3};
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle control unit: Moore main FSM sequencing the shared datapath, with a
// memory-ready stall handshake and a sticky illegal-opcode halt.
module mc_controller
  import mc_controller_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic       RegWrite,
  output logic [3:0] ALUControl,
  output logic       Illegal
);

  logic [3:0] state_reg, state_next;
  ctrl_t      ctrl;

  always_ff @(posedge clk) begin
    if (reset) state_reg <= S_FETCH;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_FETCH:    if (MemReady) state_next = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_R:         state_next = S_EXECR;
          OP_I:         state_next = S_EXECI;
          OP_BEQ:       state_next = S_BEQ;
          OP_JAL:       state_next = S_JAL;
          default:      state_next = S_HALT;
        endcase
      end
      S_MEMADR:   state_next = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (MemReady) state_next = S_MEMWB;
      S_MEMWB:    state_next = S_FETCH;
      S_MEMWRITE: if (MemReady) state_next = S_FETCH;
      S_EXECR:    state_next = S_ALUWB;
      S_EXECI:    state_next = S_ALUWB;
      S_ALUWB:    state_next = S_FETCH;
      S_BEQ:      state_next = S_FETCH;
      S_JAL:      state_next = S_ALUWB;
      S_HALT:     state_next = S_HALT;
      default:    state_next = S_FETCH;
    endcase
  end

  always_comb begin
    ctrl = '0;
    case (state_reg)
      S_FETCH: begin
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.result_src = RES_ALURESULT;
        ctrl.ir_write   = MemReady;
        ctrl.pc_update  = MemReady;
      end
      S_DECODE: begin
        ctrl.alu_src_a = SRCA_OLDPC;
        ctrl.alu_src_b = SRCB_IMM;
      end
      S_MEMADR: begin
        ctrl.alu_src_a = SRCA_RD1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      S_MEMREAD: begin
        ctrl.adr_src    = 1'b1;
        ctrl.result_src = RES_ALUOUT;
      end
      S_MEMWB: begin
        ctrl.result_src = RES_DATA;
        ctrl.reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        ctrl.adr_src    = 1'b1;
        ctrl.result_src = RES_ALUOUT;
        ctrl.mem_write  = 1'b1;
      end
      S_EXECR: begin
        ctrl.alu_src_a = SRCA_RD1;
        ctrl.alu_src_b = SRCB_RD2;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_EXECI: begin
        ctrl.alu_src_a = SRCA_RD1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl.result_src = RES_ALUOUT;
        ctrl.reg_write  = 1'b1;
      end
      S_BEQ: begin
        ctrl.alu_src_a  = SRCA_RD1;
        ctrl.alu_src_b  = SRCB_RD2;
        ctrl.alu_op     = ALUOP_SUB;
        ctrl.result_src = RES_ALUOUT;
        ctrl.branch     = 1'b1;
      end
      S_JAL: begin
        // ALU forms OldPC+4 for the link register while ALUOut already holds the target
        ctrl.alu_src_a  = SRCA_OLDPC;
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.result_src = RES_ALUOUT;
        ctrl.pc_update  = 1'b1;
      end
      S_HALT:  ctrl.illegal = 1'b1;
      default: ctrl = '0;
    endcase
  end

  mc_controller_aludec aludec (
    .opb5        (op[5]),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .alu_op      (ctrl.alu_op),
    .alu_control (ALUControl)
  );

  // Write strobes are masked by reset so a pending write never completes during reset
  assign PCWrite   = ~reset & (ctrl.pc_update | (ctrl.branch & Zero));
  assign MemWrite  = ~reset & ctrl.mem_write;
  assign IRWrite   = ~reset & ctrl.ir_write;
  assign RegWrite  = ~reset & ctrl.reg_write;
  assign Illegal   = ~reset & ctrl.illegal;
  assign AdrSrc    = ctrl.adr_src;
  assign ResultSrc = ctrl.result_src;
  assign ALUSrcA   = ctrl.alu_src_a;
  assign ALUSrcB   = ctrl.alu_src_b;
  assign ImmSrc    = imm_src(op);

endmodule

// File: doc/mc_controller.md
# mc_controller

Multicycle control unit for the RISC-V core. A Moore main FSM sequences the shared datapath: one ALU, one unified instruction/data memory port, and the IR/OldPC/ALUOut/Data registers. It decodes the opcode, stalls on a memory-ready handshake, and detects illegal opcodes. It drives the datapath muxes and enables, and produces ALUControl through an internal ALU decoder instance.

## Interface
Parameters: none.

- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- op  in  7  instruction opcode, taken from IR.
- funct3  in  3  from IR.
- funct7b5  in  1  bit 30 of IR.
- Zero  in  1  ALU zero flag.
- MemReady  in  1  memory completes the current access this cycle.
- PCWrite  out  1  PC register enable.
- AdrSrc  out  1  memory address select: 0 = PC, 1 = Result.
- MemWrite  out  1  memory write strobe.
- IRWrite  out  1  IR/OldPC enable.
- ResultSrc  out  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult.
- ALUSrcA  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = RD1.
- ALUSrcB  out  2  ALU B select: 00 = RD2, 01 = ImmExt, 10 = constant 4.
- ImmSrc  out  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J.
- RegWrite  out  1  register file write enable.
- ALUControl  out  4  ALU operation.
- Illegal  out  1  sticky illegal-opcode flag.

## Operation
- Supported opcodes: lw 0000011, sw 0100011, R-type 0110011, I-ALU 0010011, beq 1100011, jal 1101111.
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL, HALT.
- FETCH
  - Outputs: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10.
  - IRWrite and PCUpdate are asserted only when MemReady=1.
  - Holds in FETCH while MemReady=0; moves to DECODE when MemReady=1.
- DECODE
  - Outputs: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (precomputes the branch target).
  - lw/sw → MEMADR; R → EXECR; I → EXECI; beq → BEQ; jal → JAL; any other opcode → HALT.
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. lw → MEMREAD; sw → MEMWRITE.
- MEMREAD: AdrSrc=1, ResultSrc=00. Holds until MemReady=1, then → MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, → FETCH.
- MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1 held until MemReady=1, then → FETCH.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10, → ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10, → ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, → FETCH.
- BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1, → FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1, → ALUWB (writes PC+4 to rd).
- HALT: all enables 0, Illegal=1. Exits only on reset.
- PCWrite = PCUpdate | (Branch & Zero).
- ImmSrc is combinational from op: sw → 01, beq → 10, jal → 11, all others → 00.
- Mux selects not listed for a state are 00.

## Timing
- While reset=1: PCWrite, MemWrite, IRWrite, RegWrite and Illegal are forced to 0. The state is FETCH on the first edge after reset deasserts.
- Reset asserted mid-instruction returns the FSM to FETCH on the next edge. Any pending write strobe drops in that same cycle.
- Cycle counts with MemReady held at 1: lw 5, sw 4, R 4, I 4, beq 3, jal 4.
- Each cycle with MemReady=0 in FETCH, MEMREAD or MEMWRITE adds exactly one cycle. Select outputs stay stable during the stall.
- MemWrite asserted together with MemReady=1 constitutes exactly one write.
- Zero is sampled combinationally in BEQ only. PCWrite in any other state is independent of Zero.

## Structure
- Shared package holds:
  - State encoding (4-bit localparams).
  - Opcode constants.
  - ALUOp, ResultSrc, ALUSrcA/B and ImmSrc encodings.
- One sub-module: the existing aludec, instantiated with opb5=op[5], funct3, funct7b5 and the internal ALUOp, producing ALUControl.
- FSM state register and next-state/output logic live in mc_controller itself.

## Test plan
- Reset, then lw (op=0000011) with MemReady=1 → state sequence FETCH, DECODE, MEMADR, MEMREAD, MEMWB. RegWrite=1 only in cycle 5, with ResultSrc=01.
- sw with MemReady=0 for 2 cycles in MEMWRITE → MemWrite high for 3 cycles, AdrSrc=1 throughout. Returns to FETCH after the MemReady=1 cycle. ImmSrc=01.
- beq run twice, once with Zero=1 and once with Zero=0 → PCWrite=1 in the BEQ cycle only when Zero=1. ALUControl=1000 in the BEQ state in both runs.
- R-type sub (funct3=000, funct7b5=1) → ALUControl=1000 in EXECR. Same funct3 with op=0010011 → ALUControl=0000 in EXECI.
- jal → PCWrite=1 in JAL, RegWrite=1 in ALUWB, ImmSrc=11. Total of 4 cycles back to FETCH.
- op=1111111 → HALT, Illegal=1, no enables for 10 cycles. Reset asserted mid-FETCH with MemReady=0 → Illegal=0, FSM restarts in FETCH.
